// File: rtl/uart_axil_timeout_guard_if.sv
// AXI4-Lite channel bundle for the UART guard.
// The master modport drives requests; the slave modport answers them.
interface uart_axil_timeout_guard_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid,
        output wdata, wstrb, wvalid,
        output bready,
        output araddr, arvalid,
        output rready,
        input  awready, wready,
        input  bresp, bvalid,
        input  arready,
        input  rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid,
        input  wdata, wstrb, wvalid,
        input  bready,
        input  araddr, arvalid,
        input  rready,
        output awready, wready,
        output bresp, bvalid,
        output arready,
        output rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axil_timeout_guard.sv
// One-at-a-time AXI4-Lite guard in front of the UART: answers SLVERR on
// a stuck peripheral, then isolates it and drains late responses.
module uart_axil_timeout_guard #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    uart_axil_timeout_guard_if.slave  s_axil,
    uart_axil_timeout_guard_if.master m_axil,
    output logic timeout_o,
    output logic dead_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_FWD, RD_FWD, WR_RESP, RD_RESP
    } state_t;

    state_t state, state_nxt;

    logic                  last_rd;
    logic [CW-1:0]         cnt;
    logic                  dead;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            resp;
    logic                  awv, wv, arv;

    logic grant_wr, grant_rd;
    logic acc_wr, acc_rd;
    logic b_hs, r_hs, expire;

    always_comb begin
        grant_wr  = s_axil.awvalid && s_axil.wvalid &&
                    (!s_axil.arvalid || last_rd);
        grant_rd  = s_axil.arvalid && !grant_wr;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        b_hs      = (state == WR_FWD) && m_axil.bvalid;
        r_hs      = (state == RD_FWD) && m_axil.rvalid;
        // the real response wins over a same-cycle expiry
        expire    = (cnt == CNT_LAST) &&
                    (((state == WR_FWD) && !b_hs) ||
                     ((state == RD_FWD) && !r_hs));
        state_nxt = state;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    grant_wr && sys_rst_n: begin
                        acc_wr    = 1'b1;
                        state_nxt = dead ? WR_RESP : WR_FWD;
                    end
                    grant_rd && sys_rst_n: begin
                        acc_rd    = 1'b1;
                        state_nxt = dead ? RD_RESP : RD_FWD;
                    end
                    default: ;
                endcase
            end
            WR_FWD:  if (b_hs || expire) state_nxt = WR_RESP;
            RD_FWD:  if (r_hs || expire) state_nxt = RD_RESP;
            WR_RESP: if (s_axil.bready) state_nxt = IDLE;
            RD_RESP: if (s_axil.rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            last_rd   <= 1'b1;
            cnt       <= '0;
            dead      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rdata     <= '0;
            resp      <= '0;
            awv       <= 1'b0;
            wv        <= 1'b0;
            arv       <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            if (acc_wr || acc_rd)
                cnt <= '0;
            else if (state == WR_FWD || state == RD_FWD)
                cnt <= cnt + CW'(1);
            // valids already on the bus stay up until their handshake
            if (awv && m_axil.awready) awv <= 1'b0;
            if (wv && m_axil.wready)   wv  <= 1'b0;
            if (arv && m_axil.arready) arv <= 1'b0;
            if (acc_wr) begin
                last_rd <= 1'b0;
                addr    <= s_axil.awaddr;
                wdata   <= s_axil.wdata;
                wstrb   <= s_axil.wstrb;
                if (dead) resp <= SLVERR;
                else begin
                    awv <= 1'b1;
                    wv  <= 1'b1;
                end
            end
            if (acc_rd) begin
                last_rd <= 1'b1;
                addr    <= s_axil.araddr;
                if (dead) begin
                    resp  <= SLVERR;
                    rdata <= ERR_RDATA;
                end else arv <= 1'b1;
            end
            if (b_hs) resp <= m_axil.bresp;
            if (r_hs) begin
                resp  <= m_axil.rresp;
                rdata <= m_axil.rdata;
            end
            if (expire) begin
                resp      <= SLVERR;
                timeout_o <= 1'b1;
                dead      <= 1'b1;
                if (state == RD_FWD) rdata <= ERR_RDATA;
            end
        end
    end

    assign s_axil.awready = acc_wr;
    assign s_axil.wready  = acc_wr;
    assign s_axil.arready = acc_rd;
    assign s_axil.bvalid  = (state == WR_RESP);
    assign s_axil.rvalid  = (state == RD_RESP);
    assign s_axil.bresp   = resp;
    assign s_axil.rresp   = resp;
    assign s_axil.rdata   = rdata;

    assign m_axil.awaddr  = addr;
    assign m_axil.araddr  = addr;
    assign m_axil.wdata   = wdata;
    assign m_axil.wstrb   = wstrb;
    assign m_axil.awvalid = awv;
    assign m_axil.wvalid  = wv;
    assign m_axil.arvalid = arv;
    // once isolated, soak up any orphaned response forever
    assign m_axil.bready  = (state == WR_FWD) || dead;
    assign m_axil.rready  = (state == RD_FWD) || dead;

    assign dead_o = dead;
endmodule

// File: doc/uart_axil_timeout_guard.md
# uart_axil_timeout_guard

AXI4-Lite guard stage between the system's UART AXI4-Lite master port and the UART IP. Forwards one transaction at a time, with round-robin arbitration between reads and writes. If the UART fails to respond within a bounded number of cycles, it completes the transaction upstream with SLVERR, so the core never hangs on a dead peripheral. After a timeout it isolates the slave permanently (until reset) and drains orphaned responses.

## Interface
Parameters:
- ADDR_WIDTH, 13, AXI4-Lite address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 4096, cycles allowed from upstream accept to downstream response handshake; must be ≥ 2.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned with SLVERR.

Ports. Clock and reset: one clock; reset is synchronous and active-low.
- sys_clk  in  1  sole clock.
- sys_rst_n  in  1  synchronous active-low reset.
- s_axil_awaddr / s_axil_araddr  in  ADDR_WIDTH  upstream write / read address.
- s_axil_awvalid, s_axil_wvalid, s_axil_arvalid, s_axil_bready, s_axil_rready  in  1 each  upstream handshakes.
- s_axil_wdata  in  DATA_WIDTH; s_axil_wstrb  in  DATA_WIDTH/8.
- s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid  out  1 each.
- s_axil_bresp, s_axil_rresp  out  2; s_axil_rdata  out  DATA_WIDTH.
- m_axil_awaddr, m_axil_araddr  out  ADDR_WIDTH; m_axil_wdata  out  DATA_WIDTH; m_axil_wstrb  out  DATA_WIDTH/8.
- m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready  out  1 each.
- m_axil_awready, m_axil_wready, m_axil_arready, m_axil_bvalid, m_axil_rvalid  in  1 each.
- m_axil_bresp, m_axil_rresp  in  2; m_axil_rdata  in  DATA_WIDTH.
- timeout_o  out  1  one-cycle pulse when a timeout fires.
- dead_o  out  1  sticky isolation flag.

## Operation
- States: IDLE, WR_FWD, RD_FWD, WR_RESP, RD_RESP.
- IDLE, write request: eligible when s_axil_awvalid and s_axil_wvalid are both high.
  - Accept by pulsing s_axil_awready and s_axil_wready together for one cycle.
  - Register addr, data and strb.
- IDLE, read request: eligible when s_axil_arvalid is high; pulse s_axil_arready and register araddr.
- Arbitration when both are eligible: grant opposite to last_grant; last_grant resets to READ, so the first contested grant goes to the write.
- WR_FWD (not dead):
  - Assert m_awvalid and m_wvalid; each deasserts independently on its own handshake.
  - Hold m_bready=1; on m_bvalid, capture bresp and go to WR_RESP.
- RD_FWD: same flow with m_arvalid and m_rready; capture rdata and rresp, then go to RD_RESP.
- Timeout:
  - Counter clears on the accept cycle and increments each cycle in WR_FWD/RD_FWD.
  - When it reaches TIMEOUT_CYCLES with no downstream response handshake, go to *_RESP with resp=2'b10.
  - rdata=ERR_RDATA; timeout_o pulses; dead_o sets.
- Simultaneous response handshake and expiry: the real response wins; no timeout.
- Dead mode, new requests: accepted as normal but go straight to *_RESP with SLVERR (reads return ERR_RDATA); downstream is never touched.
- Dead mode, outstanding downstream transfer:
  - Any m_*valid already asserted is held until its handshake (AXI rule).
  - m_bready and m_rready are held 1 permanently to drain orphaned responses.
  - Drained responses are discarded.
- WR_RESP/RD_RESP: hold s_bvalid/s_rvalid with registered resp/data until s_*ready, then return to IDLE.
- dead_o clears only on reset.

## Timing
- Reset values: all s_*ready/valid = 0, all m_*valid = 0, m_bready = 0, m_rready = 0, resp = 0, s_rdata = 0, timeout_o = 0, dead_o = 0, state = IDLE, counter = 0.
- Accept in cycle N → m_*valid high in cycle N+1.
- Downstream response handshake in cycle M → s_*valid high in cycle M+1.
- Minimum round trip: upstream accept to upstream response valid is 3 cycles with a zero-wait slave.
- No combinational path from any m_* input to any s_* output, or the reverse.
- Timeout response: s_*valid rises TIMEOUT_CYCLES+1 cycles after the accept cycle.
- Dead-mode response: s_*valid rises the cycle after accept.
- Reset mid-transaction: every output returns to its reset value in the next cycle, regardless of the downstream handshake state.

## Test plan
- Zero-wait slave, write addr 0x004 data 0x41 strb 0xF → m_awaddr=0x004 and m_wdata=0x41 at N+1; s_bresp=00 at N+3.
- Contested: AW+W and AR valid together from reset → write granted first; the following contested cycle grants the read; strict alternation over 8 requests.
- Slave holds awready for 5 cycles and wready for 2 → each valid drops independently; a single bresp is forwarded.
- TIMEOUT_CYCLES=16, read with no m_rvalid → s_rvalid at accept+17 with rresp=10, rdata=0xDEADBEEF; timeout_o pulses once; dead_o=1.
- Dead mode: late m_rvalid drained via m_rready=1 and not forwarded; next write gets SLVERR one cycle after accept, with m_awvalid staying 0.
- m_bvalid handshake in the same cycle the counter expires → OKAY forwarded; timeout_o=0, dead_o=0.
- Assert sys_rst_n=0 during WR_FWD → all outputs reach reset values the next cycle; dead_o=0.
